// File: rtl/vend_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_pkg: shared state, coin and price definitions for vend_seq_ctrl|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;

  localparam int unsigned COIN_VAL_5  = 5;
  localparam int unsigned COIN_VAL_10 = 10;

  function automatic int unsigned item_price(input logic [1:0] id,
                                             input int unsigned p0,
                                             input int unsigned p1,
                                             input int unsigned p2,
                                             input int unsigned p3);
    case (id)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return p2;
      default: return p3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_seq_ctrl_if: coin, keypad, dispense and change signal bundle   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface vend_seq_ctrl_if #(
  parameter int unsigned CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin_in;
  logic                coin_rej;
  logic                sel_valid;
  logic [1:0]          sel_id;
  logic                sel_nack;
  logic                cancel;
  logic                disp_req;
  logic [1:0]          disp_id;
  logic                disp_ack;
  logic                chg_req;
  logic                chg_coin;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                fault;

  modport slave (
    input  coin_valid, coin_in, sel_valid, sel_id, cancel, disp_ack, chg_ack,
    output coin_rej, sel_nack, disp_req, disp_id, chg_req, chg_coin, credit, busy, fault
  );

  modport master (
    output coin_valid, coin_in, sel_valid, sel_id, cancel, disp_ack, chg_ack,
    input  coin_rej, sel_nack, disp_req, disp_id, chg_req, chg_coin, credit, busy, fault
  );
endinterface
`default_nettype wire

// File: rtl/vend_change_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_change_unit: pays out the outstanding amount one coin at a time|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CREDIT_W-1:0] amount,
  input  logic                chg_ack,
  output logic                chg_req,
  output logic                chg_coin,
  output logic                done
);

  logic r_req;
  logic r_coin;

  // amount is decremented by the owner on the ack edge, so a fresh request
  // can only start after one low cycle and always sees the updated amount
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= 1'b0;
      r_coin <= 1'b0;
    end else if (!start) begin
      r_req  <= 1'b0;
    end else if (r_req) begin
      if (chg_ack) r_req <= 1'b0;
    end else if (amount != '0) begin
      r_req  <= 1'b1;
      r_coin <= (amount >= CREDIT_W'(COIN_VAL_10));
    end
  end

  assign chg_req  = r_req;
  assign chg_coin = r_coin;
  assign done     = start && !r_req && (amount == '0);

endmodule
`default_nettype wire

// File: rtl/vend_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_seq_ctrl: vending transaction sequencer (credit, dispense,     |
// | change payout, refund and dispense-timeout fault)                   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned MAX_CREDIT = 50,
  parameter int unsigned PRICE0     = 15,
  parameter int unsigned PRICE1     = 20,
  parameter int unsigned PRICE2     = 25,
  parameter int unsigned PRICE3     = 30,
  parameter int unsigned IDLE_TO    = 1000,
  parameter int unsigned ACK_TO     = 255
) (
  input logic             clk,
  input logic             rst_n,
  vend_seq_ctrl_if.slave  bus
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TO + 1);
  localparam int unsigned ACK_W  = $clog2(ACK_TO + 1);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [IDLE_W-1:0]   r_idle_cnt, w_idle_cnt_nxt;
  logic [ACK_W-1:0]    r_ack_cnt, w_ack_cnt_nxt;
  logic [1:0]          r_disp_id, w_disp_id_nxt;
  logic                r_disp_req, w_disp_req_nxt;
  logic                r_coin_rej, w_coin_rej_nxt;
  logic                r_sel_nack, w_sel_nack_nxt;
  logic                r_fault, w_fault_nxt;

  logic [CREDIT_W-1:0] w_coin_val, w_sel_price, w_disp_price, w_base, w_coin_add;
  logic                w_coin_code_ok, w_coin_fits, w_coin_acc, w_sel_ok;
  logic                w_chg_req, w_chg_coin, w_chg_done;

  always_comb begin
    w_coin_val     = '0;
    w_coin_code_ok = 1'b0;
    case (bus.coin_in)
      COIN_5:  begin w_coin_val = CREDIT_W'(COIN_VAL_5);  w_coin_code_ok = 1'b1; end
      COIN_10: begin w_coin_val = CREDIT_W'(COIN_VAL_10); w_coin_code_ok = 1'b1; end
      default: ;
    endcase
  end

  assign w_sel_price  = CREDIT_W'(item_price(bus.sel_id, PRICE0, PRICE1, PRICE2, PRICE3));
  assign w_disp_price = CREDIT_W'(item_price(r_disp_id, PRICE0, PRICE1, PRICE2, PRICE3));
  assign w_sel_ok     = (r_state == ST_CREDIT) && bus.sel_valid && !bus.cancel &&
                        (r_credit >= w_sel_price);

  // A same-cycle coin lands after the price is taken, so test overflow on that base
  assign w_base      = w_sel_ok ? (r_credit - w_sel_price) : r_credit;
  assign w_coin_fits = ({1'b0, w_base} + {1'b0, w_coin_val}) <= (CREDIT_W + 1)'(MAX_CREDIT);
  assign w_coin_acc  = bus.coin_valid && w_coin_code_ok && w_coin_fits &&
                       ((r_state == ST_IDLE) || (r_state == ST_CREDIT));
  assign w_coin_add  = w_coin_acc ? w_coin_val : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_idle_cnt_nxt = r_idle_cnt;
    w_ack_cnt_nxt  = r_ack_cnt;
    w_disp_id_nxt  = r_disp_id;
    w_disp_req_nxt = r_disp_req;
    w_fault_nxt    = r_fault;
    w_sel_nack_nxt = 1'b0;
    w_coin_rej_nxt = bus.coin_valid && !w_coin_acc;
    case (r_state)
      ST_IDLE: begin
        if (w_coin_acc) begin
          w_credit_nxt   = r_credit + w_coin_add;
          w_idle_cnt_nxt = '0;
          w_state_nxt    = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (bus.cancel) begin
          w_credit_nxt = r_credit + w_coin_add;
          w_state_nxt  = ST_CHANGE;
        end else if (w_sel_ok) begin
          w_credit_nxt   = w_base + w_coin_add;
          w_disp_id_nxt  = bus.sel_id;
          w_disp_req_nxt = 1'b1;
          w_ack_cnt_nxt  = '0;
          w_state_nxt    = ST_DISPENSE;
        end else begin
          w_sel_nack_nxt = bus.sel_valid;
          w_credit_nxt   = r_credit + w_coin_add;
          if (w_coin_acc || bus.sel_valid) begin
            w_idle_cnt_nxt = '0;
          end else if (r_idle_cnt == IDLE_W'(IDLE_TO - 1)) begin
            w_idle_cnt_nxt = '0;
            w_state_nxt    = ST_CHANGE;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
          end
        end
      end
      ST_DISPENSE: begin
        if (bus.disp_ack) begin
          w_disp_req_nxt = 1'b0;
          w_state_nxt    = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (r_ack_cnt == ACK_W'(ACK_TO - 1)) begin
          // Actuator never answered: flag it and hand the price back as change
          w_fault_nxt    = 1'b1;
          w_disp_req_nxt = 1'b0;
          w_credit_nxt   = r_credit + w_disp_price;
          w_state_nxt    = ST_CHANGE;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + ACK_W'(1);
        end
      end
      ST_CHANGE: begin
        if (w_chg_req && bus.chg_ack) begin
          w_credit_nxt = r_credit - (w_chg_coin ? CREDIT_W'(COIN_VAL_10) : CREDIT_W'(COIN_VAL_5));
        end else if (w_chg_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_idle_cnt <= '0;
      r_ack_cnt  <= '0;
      r_disp_id  <= '0;
      r_disp_req <= 1'b0;
      r_coin_rej <= 1'b0;
      r_sel_nack <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_ack_cnt  <= w_ack_cnt_nxt;
      r_disp_id  <= w_disp_id_nxt;
      r_disp_req <= w_disp_req_nxt;
      r_coin_rej <= w_coin_rej_nxt;
      r_sel_nack <= w_sel_nack_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  vend_change_unit #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (r_state == ST_CHANGE),
    .amount   (r_credit),
    .chg_ack  (bus.chg_ack),
    .chg_req  (w_chg_req),
    .chg_coin (w_chg_coin),
    .done     (w_chg_done)
  );

  assign bus.coin_rej = r_coin_rej;
  assign bus.sel_nack = r_sel_nack;
  assign bus.disp_req = r_disp_req;
  assign bus.disp_id  = r_disp_id;
  assign bus.chg_req  = w_chg_req;
  assign bus.chg_coin = w_chg_coin;
  assign bus.credit   = r_credit;
  assign bus.busy     = (r_state == ST_DISPENSE) || (r_state == ST_CHANGE);
  assign bus.fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_vend_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vend_seq_ctrl: directed and randomized bench for vend_seq_ctrl   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_vend_seq_ctrl;

  localparam int unsigned TB_IDLE_TO = 40;
  localparam int unsigned TB_ACK_TO  = 16;
  localparam int          MAXC       = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   prices[4] = '{15, 20, 25, 30};

  vend_seq_ctrl_if #(.CREDIT_W(8)) bus ();

  vend_seq_ctrl #(
    .IDLE_TO (TB_IDLE_TO),
    .ACK_TO  (TB_ACK_TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] code);
    bus.coin_in = code; bus.coin_valid = 1'b1; cyc(); bus.coin_valid = 1'b0;
  endtask

  task automatic press_sel(input logic [1:0] id);
    bus.sel_id = id; bus.sel_valid = 1'b1; cyc(); bus.sel_valid = 1'b0;
  endtask

  task automatic press_cancel();
    bus.cancel = 1'b1; cyc(); bus.cancel = 1'b0;
  endtask

  // Serve a refund of amt: greedy 10s then a 5, credit tracked after each ack
  task automatic pay_out(input int amt, input string tag);
    int rem = amt;
    int k;
    logic exp_coin;
    while (rem > 0) begin
      exp_coin = (rem >= 10);
      k = 0;
      while (bus.chg_req !== 1'b1 && k < 20) begin cyc(); k++; end
      n_total++;
      if (bus.chg_req !== 1'b1) begin
        $display("FAIL %s chg_req_wait got %b want 1", tag, bus.chg_req);
        return;
      end else n_pass++;
      n_total++;
      if (bus.chg_coin !== exp_coin) $display("FAIL %s chg_coin got %b want %b", tag, bus.chg_coin, exp_coin);
      else n_pass++;
      repeat ($urandom_range(0, 3)) cyc();
      bus.chg_ack = 1'b1; cyc(); bus.chg_ack = 1'b0;
      rem -= exp_coin ? 10 : 5;
      n_total++;
      if (bus.credit !== 8'(rem) || bus.chg_req !== 1'b0)
        $display("FAIL %s after_ack credit=%0d req=%b want credit=%0d req=0", tag, bus.credit, bus.chg_req, rem);
      else n_pass++;
    end
    k = 0;
    while (bus.busy !== 1'b0 && k < 10) begin cyc(); k++; end
    n_total++;
    if (bus.busy !== 1'b0 || bus.credit !== 8'd0)
      $display("FAIL %s end busy=%b credit=%0d want busy=0 credit=0", tag, bus.busy, bus.credit);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_total++;
    if ({bus.credit, bus.busy, bus.fault, bus.disp_req, bus.chg_req, bus.coin_rej, bus.sel_nack} !== 14'd0)
      $display("FAIL reset credit=%0d busy=%b fault=%b dreq=%b creq=%b rej=%b nack=%b want all 0",
               bus.credit, bus.busy, bus.fault, bus.disp_req, bus.chg_req, bus.coin_rej, bus.sel_nack);
    else n_pass++;
  endtask

  task automatic test_exact_pay();
    put_coin(2'b10); put_coin(2'b01);
    n_total++;
    if (bus.credit !== 8'd15) $display("FAIL exact credit got %0d want 15", bus.credit); else n_pass++;
    press_sel(2'd0);
    n_total++;
    if (bus.disp_req !== 1'b1 || bus.disp_id !== 2'd0 || bus.credit !== 8'd0 || bus.busy !== 1'b1)
      $display("FAIL exact dispense req=%b id=%0d credit=%0d busy=%b want 1/0/0/1", bus.disp_req, bus.disp_id, bus.credit, bus.busy);
    else n_pass++;
    cyc(); cyc();
    bus.disp_ack = 1'b1; cyc(); bus.disp_ack = 1'b0;
    n_total++;
    if (bus.disp_req !== 1'b0 || bus.busy !== 1'b0) $display("FAIL exact after_ack req=%b busy=%b want 0/0", bus.disp_req, bus.busy);
    else n_pass++;
    repeat (3) cyc();
    n_total++;
    if (bus.chg_req !== 1'b0 || bus.credit !== 8'd0) $display("FAIL exact no_change req=%b credit=%0d want 0/0", bus.chg_req, bus.credit);
    else n_pass++;
  endtask

  task automatic test_change();
    put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
    press_sel(2'd1);
    n_total++;
    if (bus.disp_req !== 1'b1 || bus.disp_id !== 2'd1 || bus.credit !== 8'd10)
      $display("FAIL change dispense req=%b id=%0d credit=%0d want 1/1/10", bus.disp_req, bus.disp_id, bus.credit);
    else n_pass++;
    bus.disp_ack = 1'b1; cyc(); bus.disp_ack = 1'b0;
    pay_out(10, "change");
  endtask

  task automatic test_underpay_cancel();
    put_coin(2'b01);
    press_sel(2'd3);
    n_total++;
    if (bus.sel_nack !== 1'b1 || bus.credit !== 8'd5 || bus.disp_req !== 1'b0)
      $display("FAIL underpay nack=%b credit=%0d dreq=%b want 1/5/0", bus.sel_nack, bus.credit, bus.disp_req);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.sel_nack !== 1'b0) $display("FAIL underpay nack_pulse got %b want 0", bus.sel_nack); else n_pass++;
    press_cancel();
    pay_out(5, "cancel");
  endtask

  task automatic test_reject();
    // idle-state handshakes and selections must be ignored
    bus.disp_ack = 1'b1; bus.chg_ack = 1'b1; bus.cancel = 1'b1; press_sel(2'd0);
    bus.disp_ack = 1'b0; bus.chg_ack = 1'b0; bus.cancel = 1'b0;
    n_total++;
    if (bus.sel_nack !== 1'b0 || bus.busy !== 1'b0 || bus.credit !== 8'd0)
      $display("FAIL idle_ignore nack=%b busy=%b credit=%0d want 0/0/0", bus.sel_nack, bus.busy, bus.credit);
    else n_pass++;
    put_coin(2'b11);
    n_total++;
    if (bus.coin_rej !== 1'b1 || bus.credit !== 8'd0) $display("FAIL idle_invalid rej=%b credit=%0d want 1/0", bus.coin_rej, bus.credit);
    else n_pass++;
    repeat (4) put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b10);
    n_total++;
    if (bus.coin_rej !== 1'b1 || bus.credit !== 8'd45) $display("FAIL overflow rej=%b credit=%0d want 1/45", bus.coin_rej, bus.credit);
    else n_pass++;
    put_coin(2'b00);
    n_total++;
    if (bus.coin_rej !== 1'b1 || bus.credit !== 8'd45) $display("FAIL invalid00 rej=%b credit=%0d want 1/45", bus.coin_rej, bus.credit);
    else n_pass++;
    put_coin(2'b01);
    n_total++;
    if (bus.coin_rej !== 1'b0 || bus.credit !== 8'd50) $display("FAIL at_max rej=%b credit=%0d want 0/50", bus.coin_rej, bus.credit);
    else n_pass++;
    press_sel(2'd3);
    put_coin(2'b01);
    n_total++;
    if (bus.coin_rej !== 1'b1 || bus.credit !== 8'd20 || bus.disp_req !== 1'b1)
      $display("FAIL busy_coin rej=%b credit=%0d dreq=%b want 1/20/1", bus.coin_rej, bus.credit, bus.disp_req);
    else n_pass++;
    bus.disp_ack = 1'b1; cyc(); bus.disp_ack = 1'b0;
    pay_out(20, "reject");
  endtask

  task automatic test_same_cycle();
    put_coin(2'b10); put_coin(2'b10);
    bus.coin_in = 2'b01; bus.coin_valid = 1'b1; press_sel(2'd1); bus.coin_valid = 1'b0;
    n_total++;
    if (bus.disp_req !== 1'b1 || bus.credit !== 8'd5 || bus.coin_rej !== 1'b0)
      $display("FAIL coin_sel dreq=%b credit=%0d rej=%b want 1/5/0", bus.disp_req, bus.credit, bus.coin_rej);
    else n_pass++;
    bus.disp_ack = 1'b1; cyc(); bus.disp_ack = 1'b0;
    pay_out(5, "coin_sel");
    put_coin(2'b10); put_coin(2'b01);
    bus.coin_in = 2'b10; bus.coin_valid = 1'b1; press_sel(2'd2); bus.coin_valid = 1'b0;
    n_total++;
    if (bus.sel_nack !== 1'b1 || bus.credit !== 8'd25 || bus.disp_req !== 1'b0)
      $display("FAIL coin_sel_nack nack=%b credit=%0d dreq=%b want 1/25/0", bus.sel_nack, bus.credit, bus.disp_req);
    else n_pass++;
    bus.cancel = 1'b1; press_sel(2'd0); bus.cancel = 1'b0;
    n_total++;
    if (bus.sel_nack !== 1'b0 || bus.disp_req !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL cancel_sel nack=%b dreq=%b busy=%b want 0/0/1", bus.sel_nack, bus.disp_req, bus.busy);
    else n_pass++;
    pay_out(25, "cancel_sel");
    put_coin(2'b01);
    bus.coin_in = 2'b10; bus.coin_valid = 1'b1; press_cancel(); bus.coin_valid = 1'b0;
    n_total++;
    if (bus.credit !== 8'd15 || bus.coin_rej !== 1'b0) $display("FAIL coin_cancel credit=%0d rej=%b want 15/0", bus.credit, bus.coin_rej);
    else n_pass++;
    pay_out(15, "coin_cancel");
  endtask

  task automatic test_fault();
    put_coin(2'b10); put_coin(2'b10);
    press_sel(2'd0);
    repeat (TB_ACK_TO - 1) cyc();
    n_total++;
    if (bus.fault !== 1'b0 || bus.disp_req !== 1'b1) $display("FAIL fault_early fault=%b dreq=%b want 0/1", bus.fault, bus.disp_req);
    else n_pass++;
    cyc();
    n_total++;
    if (bus.fault !== 1'b1 || bus.disp_req !== 1'b0 || bus.credit !== 8'd20)
      $display("FAIL fault_fire fault=%b dreq=%b credit=%0d want 1/0/20", bus.fault, bus.disp_req, bus.credit);
    else n_pass++;
    pay_out(20, "fault");
    n_total++;
    if (bus.fault !== 1'b1) $display("FAIL fault_sticky got %b want 1", bus.fault); else n_pass++;
  endtask

  task automatic test_async_reset();
    put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
    press_cancel();
    repeat (3) if (bus.chg_req !== 1'b1) cyc();
    n_total++;
    if (bus.chg_req !== 1'b1) $display("FAIL arst_setup chg_req got %b want 1", bus.chg_req); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.chg_req !== 1'b0 || bus.credit !== 8'd0 || bus.busy !== 1'b0 || bus.fault !== 1'b0)
      $display("FAIL arst_now creq=%b credit=%0d busy=%b fault=%b want 0/0/0/0", bus.chg_req, bus.credit, bus.busy, bus.fault);
    else n_pass++;
    cyc();
    rst_n = 1'b1;
    cyc();
    put_coin(2'b01);
    n_total++;
    if (bus.credit !== 8'd5 || bus.busy !== 1'b0) $display("FAIL arst_idle credit=%0d busy=%b want 5/0", bus.credit, bus.busy);
    else n_pass++;
    press_cancel();
    pay_out(5, "arst");
  endtask

  task automatic test_random();
    int m, since, code, v, act, id, rem;
    logic acc;
    for (int s = 0; s < 30; s++) begin
      m = 0; since = 0;
      for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
        code = $urandom_range(0, 3);
        v    = (code == 1) ? 5 : (code == 2) ? 10 : 0;
        acc  = (v != 0) && (m + v <= MAXC);
        put_coin(2'(code));
        if (acc) begin m += v; since = 0; end else if (m > 0) since++;
        n_total++;
        if (bus.coin_rej !== !acc || bus.credit !== 8'(m))
          $display("FAIL rnd_coin rej=%b credit=%0d want rej=%b credit=%0d", bus.coin_rej, bus.credit, !acc, m);
        else n_pass++;
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin cyc(); if (m > 0) since++; end
      end
      if (m == 0) continue;
      act = $urandom_range(0, 2);
      if (act == 0) begin
        id = $urandom_range(0, 3);
        press_sel(2'(id));
        if (m < prices[id]) begin
          n_total++;
          if (bus.sel_nack !== 1'b1 || bus.credit !== 8'(m)) $display("FAIL rnd_nack nack=%b credit=%0d want 1/%0d", bus.sel_nack, bus.credit, m);
          else n_pass++;
          press_cancel();
          pay_out(m, "rnd_nack");
        end else begin
          rem = m - prices[id];
          n_total++;
          if (bus.disp_req !== 1'b1 || bus.disp_id !== 2'(id) || bus.credit !== 8'(rem))
            $display("FAIL rnd_disp req=%b id=%0d credit=%0d want 1/%0d/%0d", bus.disp_req, bus.disp_id, bus.credit, id, rem);
          else n_pass++;
          for (int d = 0; d < int'($urandom_range(0, 5)); d++) begin
            bus.chg_ack = 1'($urandom_range(0, 1)); cyc(); bus.chg_ack = 1'b0;
          end
          bus.disp_ack = 1'b1; cyc(); bus.disp_ack = 1'b0;
          pay_out(rem, "rnd_disp");
        end
      end else if (act == 1) begin
        press_cancel();
        pay_out(m, "rnd_cancel");
      end else begin
        repeat (TB_IDLE_TO - since - 1) cyc();
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL rnd_to_early busy got %b want 0", bus.busy); else n_pass++;
        cyc();
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL rnd_to_fire busy got %b want 1", bus.busy); else n_pass++;
        pay_out(m, "rnd_timeout");
      end
    end
  endtask

  initial begin
    bus.coin_valid = 1'b0; bus.coin_in = 2'b00; bus.sel_valid = 1'b0; bus.sel_id = 2'd0;
    bus.cancel = 1'b0; bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
    repeat (3) cyc();
    test_reset();
    rst_n = 1'b1;
    cyc();
    test_exact_pay();
    test_change();
    test_underpay_cancel();
    test_reject();
    test_same_cycle();
    test_async_reset();
    test_fault();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
